// File: rtl/sd_frame_sector_writer.sv
// Packs 16-bit pixel words into ping-pong 512-byte sector banks and streams each full bank to the SD controller.
// Latency: a bank filled this cycle starts a write two cycles later; wr_data follows each wr_req by one cycle.
// Backpressure: pix_ready drops while the fill bank awaits its write; SD_PAD_PARTIAL_EN pads a partial final sector.
module sd_frame_sector_writer #(
    parameter int unsigned SEC_WORDS = 256,
    parameter int unsigned ADDR_W    = 32,
    parameter logic [15:0] PAD_WORD  = 16'h0000
) (
    input  logic              clk_ref,
    input  logic              rst,
    input  logic              frame_start,
    input  logic [ADDR_W-1:0] base_sec_addr,
    input  logic              pix_valid,
    input  logic [15:0]       pix_data,
    output logic              pix_ready,
    input  logic              frame_end,
    input  logic              sd_init_done,
    input  logic              wr_busy,
    input  logic              wr_req,
    output logic              wr_start_en,
    output logic [ADDR_W-1:0] wr_sec_addr,
    output logic [15:0]       wr_data,
    output logic [ADDR_W-1:0] sec_cnt,
    output logic              frame_done,
    output logic              overflow
);

    localparam int unsigned   PW       = $clog2(SEC_WORDS);
    localparam int unsigned   IW       = PW + 1;
    localparam logic [PW-1:0] PTR_LAST = PW'(SEC_WORDS - 1);
    localparam logic [IW-1:0] IDX_END  = IW'(SEC_WORDS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT_BUSY,
        ST_XFER,
        ST_WAIT_DONE
    } state_t;

    state_t            state_q, state_d;
    logic              armed_q, armed_d;
    logic              end_pend_q, end_pend_d;
    logic              pad_q, pad_d;
    logic [1:0]        pend_q, pend_d;
    logic              fill_bank_q, fill_bank_d;
    logic [PW-1:0]     fill_ptr_q, fill_ptr_d;
    logic              wr_bank_q, wr_bank_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] sec_cnt_q, sec_cnt_d;
    logic [ADDR_W-1:0] wr_sec_addr_q, wr_sec_addr_d;
    logic [15:0]       wr_data_q, wr_data_d;
    logic              wr_start_en_q, wr_start_en_d;
    logic              frame_done_q, frame_done_d;
    logic              overflow_q, overflow_d;

    logic [15:0]       mem_q [2][SEC_WORDS];
    logic              mem_we;
    logic [15:0]       mem_wdat;
    logic [PW-1:0]     rd_addr;
    logic [15:0]       rd_dat;
    logic              pix_acc;

    assign pix_ready = armed_q && !pend_q[fill_bank_q];
    assign pix_acc   = pix_valid && pix_ready;

    // In XFER the register is loaded with the word after the one being consumed.
    assign rd_addr = (state_q == ST_XFER) ? idx_q[PW-1:0] + 1'b1 : '0;
    assign rd_dat  = mem_q[wr_bank_q][rd_addr];

    always_ff @(posedge clk_ref) begin
        if (mem_we) begin
            mem_q[fill_bank_q][fill_ptr_q] <= mem_wdat;
        end
    end

    always_comb begin
        state_d       = state_q;
        armed_d       = armed_q;
        end_pend_d    = end_pend_q;
        pad_d         = pad_q;
        pend_d        = pend_q;
        fill_bank_d   = fill_bank_q;
        fill_ptr_d    = fill_ptr_q;
        wr_bank_d     = wr_bank_q;
        idx_d         = idx_q;
        base_d        = base_q;
        sec_cnt_d     = sec_cnt_q;
        wr_sec_addr_d = wr_sec_addr_q;
        wr_data_d     = wr_data_q;
        wr_start_en_d = 1'b0;
        frame_done_d  = 1'b0;
        overflow_d    = overflow_q;
        mem_we        = 1'b0;
        mem_wdat      = pix_data;

        if (pix_acc || pad_q) begin
            mem_we     = 1'b1;
            mem_wdat   = pad_q ? PAD_WORD : pix_data;
            fill_ptr_d = fill_ptr_q + 1'b1;
            if (fill_ptr_q == PTR_LAST) begin
                pend_d[fill_bank_q] = 1'b1;
                fill_bank_d         = ~fill_bank_q;
                pad_d               = 1'b0;
            end
        end

        if (armed_q && pix_valid && !pix_ready) begin
            overflow_d = 1'b1;
        end

        if (armed_q && frame_end) begin
            armed_d    = 1'b0;
            end_pend_d = 1'b1;
            if (fill_ptr_d != '0) begin
`ifdef SD_PAD_PARTIAL_EN
                pad_d = 1'b1;
`else
                fill_ptr_d = '0;
`endif
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (pend_q[wr_bank_q] && sd_init_done && !wr_busy) begin
                    state_d       = ST_START;
                    wr_start_en_d = 1'b1;
                    wr_sec_addr_d = base_q + sec_cnt_q;
                    idx_d         = '0;
                    wr_data_d     = rd_dat;
                end
            end
            ST_START: state_d = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                if (wr_busy) begin
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (wr_req) begin
                    idx_d = idx_q + 1'b1;
                    if (idx_d == IDX_END) begin
                        wr_data_d = PAD_WORD;
                        state_d   = ST_WAIT_DONE;
                    end else begin
                        wr_data_d = rd_dat;
                    end
                end
            end
            ST_WAIT_DONE: begin
                wr_data_d = PAD_WORD;
                if (!wr_busy) begin
                    pend_d[wr_bank_q] = 1'b0;
                    wr_bank_d         = ~wr_bank_q;
                    sec_cnt_d         = sec_cnt_q + 1'b1;
                    state_d           = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Done once the frame has ended and nothing remains to pad or write.
        if (end_pend_d && !pad_d && (pend_d == 2'b00)) begin
            frame_done_d = 1'b1;
            end_pend_d   = 1'b0;
        end

        if (frame_start && (state_q == ST_IDLE) && (pend_q == 2'b00) && !pad_q) begin
            base_d       = base_sec_addr;
            sec_cnt_d    = '0;
            overflow_d   = 1'b0;
            fill_ptr_d   = '0;
            fill_bank_d  = 1'b0;
            wr_bank_d    = 1'b0;
            pend_d       = 2'b00;
            armed_d      = 1'b1;
            end_pend_d   = 1'b0;
            pad_d        = 1'b0;
            frame_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk_ref or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            armed_q       <= 1'b0;
            end_pend_q    <= 1'b0;
            pad_q         <= 1'b0;
            pend_q        <= 2'b00;
            fill_bank_q   <= 1'b0;
            fill_ptr_q    <= '0;
            wr_bank_q     <= 1'b0;
            idx_q         <= '0;
            base_q        <= '0;
            sec_cnt_q     <= '0;
            wr_sec_addr_q <= '0;
            wr_data_q     <= '0;
            wr_start_en_q <= 1'b0;
            frame_done_q  <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            armed_q       <= armed_d;
            end_pend_q    <= end_pend_d;
            pad_q         <= pad_d;
            pend_q        <= pend_d;
            fill_bank_q   <= fill_bank_d;
            fill_ptr_q    <= fill_ptr_d;
            wr_bank_q     <= wr_bank_d;
            idx_q         <= idx_d;
            base_q        <= base_d;
            sec_cnt_q     <= sec_cnt_d;
            wr_sec_addr_q <= wr_sec_addr_d;
            wr_data_q     <= wr_data_d;
            wr_start_en_q <= wr_start_en_d;
            frame_done_q  <= frame_done_d;
            overflow_q    <= overflow_d;
        end
    end

    assign wr_start_en = wr_start_en_q;
    assign wr_sec_addr = wr_sec_addr_q;
    assign wr_data     = wr_data_q;
    assign sec_cnt     = sec_cnt_q;
    assign frame_done  = frame_done_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_sd_frame_sector_writer.sv
// Directed bench for sd_frame_sector_writer: pixel streaming, a modelled SD controller, reset and padding cases.
module tb_sd_frame_sector_writer;

    localparam logic [15:0] PAD = 16'h0000;

    logic        clk_ref       = 1'b0;
    logic        rst           = 1'b1;
    logic        frame_start   = 1'b0;
    logic [31:0] base_sec_addr = '0;
    logic        pix_valid     = 1'b0;
    logic [15:0] pix_data      = '0;
    logic        pix_ready;
    logic        frame_end     = 1'b0;
    logic        sd_init_done  = 1'b0;
    logic        wr_busy       = 1'b0;
    logic        wr_req        = 1'b0;
    logic        wr_start_en;
    logic [31:0] wr_sec_addr;
    logic [15:0] wr_data;
    logic [31:0] sec_cnt;
    logic        frame_done;
    logic        overflow;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    sd_frame_sector_writer dut (
        .clk_ref       (clk_ref),
        .rst           (rst),
        .frame_start   (frame_start),
        .base_sec_addr (base_sec_addr),
        .pix_valid     (pix_valid),
        .pix_data      (pix_data),
        .pix_ready     (pix_ready),
        .frame_end     (frame_end),
        .sd_init_done  (sd_init_done),
        .wr_busy       (wr_busy),
        .wr_req        (wr_req),
        .wr_start_en   (wr_start_en),
        .wr_sec_addr   (wr_sec_addr),
        .wr_data       (wr_data),
        .sec_cnt       (sec_cnt),
        .frame_done    (frame_done),
        .overflow      (overflow)
    );

    always #5 clk_ref = ~clk_ref;

    task automatic tick();
        @(posedge clk_ref);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic pulse_start(input logic [31:0] base);
        base_sec_addr = base;
        frame_start   = 1'b1;
        tick();
        frame_start   = 1'b0;
    endtask

    task automatic pulse_end();
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
    endtask

    // Presents words v0, v0+1, ... until n are accepted; optionally raises frame_end with the last one.
    task automatic stream(input int n, input logic [15:0] v0, input bit with_end, output int acc_cnt);
        int  cyc = 0;
        bit  ok;
        acc_cnt = 0;
        while (acc_cnt < n && cyc < 4 * n + 100) begin
            pix_valid = 1'b1;
            pix_data  = v0 + 16'(acc_cnt);
            ok        = pix_ready;
            frame_end = with_end && (acc_cnt == n - 1) && ok;
            tick();
            if (ok) acc_cnt++;
            cyc++;
        end
        pix_valid = 1'b0;
        frame_end = 1'b0;
    endtask

    task automatic wait_start(input string tag, input logic [31:0] exp_addr, input int budget);
        int n    = 0;
        bit seen = 1'b0;
        while (!seen && n < budget) begin
            tick();
            n++;
            if (wr_start_en) seen = 1'b1;
        end
        check({tag, "_start_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check({tag, "_addr"}, wr_sec_addr, exp_addr);
            tick();
            check({tag, "_start_one_cycle"}, 32'(wr_start_en), 32'd0);
        end
    endtask

    task automatic count_starts(input int ncyc, output int cnt);
        cnt = 0;
        for (int i = 0; i < ncyc; i++) begin
            tick();
            if (wr_start_en) cnt++;
        end
    endtask

    // Controller model: raise busy, then issue nreq back-to-back wr_req, checking each word before it is taken.
    task automatic ctrl_reqs(input string tag, input logic [15:0] first, input int ndata, input int nreq);
        int          bad = 0;
        logic [15:0] exp_w;
        repeat (8) tick();
        wr_busy = 1'b1;
        tick();
        tick();
        for (int k = 0; k < nreq; k++) begin
            exp_w = (k < ndata) ? first + 16'(k) : PAD;
            if (wr_data !== exp_w) bad++;
            wr_req = 1'b1;
            tick();
        end
        wr_req = 1'b0;
        check({tag, "_data_errs"}, 32'(bad), 32'd0);
    endtask

    task automatic ctrl_finish(input string tag, input bit exp_done, input logic [31:0] exp_sec);
        repeat (3) tick();
        wr_busy = 1'b0;
        tick();
        check({tag, "_frame_done"}, 32'(frame_done), 32'(exp_done));
        check({tag, "_sec_cnt"}, sec_cnt, exp_sec);
    endtask

    initial begin
        int acc;
        int acc2;
        int first_drop;
        int nst;

        // Reset state, checked before any clock edge.
        #2;
        check("rst_wr_start_en", 32'(wr_start_en), 32'd0);
        check("rst_wr_sec_addr", wr_sec_addr, 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_sec_cnt", sec_cnt, 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_pix_ready", 32'(pix_ready), 32'd0);
        tick();
        rst = 1'b0;
        sd_init_done = 1'b1;
        tick();
        check("unarmed_pix_ready", 32'(pix_ready), 32'd0);

        // 1: two full sectors at 0x1000/0x1001.
        pulse_start(32'h0000_1000);
        check("t1_pix_ready", 32'(pix_ready), 32'd1);
        fork
            begin
                stream(512, 16'd0, 1'b0, acc);
                check("t1_accepted", 32'(acc), 32'd512);
                pulse_end();
                check("t1_ready_after_end", 32'(pix_ready), 32'd0);
            end
            begin
                wait_start("t1_s0", 32'h0000_1000, 2000);
                ctrl_reqs("t1_s0", 16'd0, 256, 256);
                ctrl_finish("t1_s0", 1'b0, 32'd1);
                wait_start("t1_s1", 32'h0000_1001, 2000);
                ctrl_reqs("t1_s1", 16'd256, 256, 256);
                ctrl_finish("t1_s1", 1'b1, 32'd2);
                tick();
                check("t1_done_one_pulse", 32'(frame_done), 32'd0);
            end
        join

        // 2: controller busy while 600 words are offered back to back.
        pulse_start(32'h0000_2000);
        wr_busy = 1'b1;
        acc = 0;
        first_drop = -1;
        for (int i = 0; i < 600; i++) begin
            pix_valid = 1'b1;
            pix_data  = 16'(i);
            if (pix_ready) acc++;
            else if (first_drop < 0) first_drop = i;
            tick();
        end
        pix_valid = 1'b0;
        check("t2_accepted", 32'(acc), 32'd512);
        check("t2_first_drop", 32'(first_drop), 32'd512);
        check("t2_overflow", 32'(overflow), 32'd1);
        wr_busy = 1'b0;
        wait_start("t2_s0", 32'h0000_2000, 20);
        ctrl_reqs("t2_s0", 16'd0, 256, 256);
        ctrl_finish("t2_s0", 1'b0, 32'd1);
        wait_start("t2_s1", 32'h0000_2001, 20);
        ctrl_reqs("t2_s1", 16'd256, 256, 256);
        ctrl_finish("t2_s1", 1'b0, 32'd2);
        check("t2_overflow_sticky", 32'(overflow), 32'd1);
        pulse_start(32'h0000_3000);
        check("t2_overflow_cleared", 32'(overflow), 32'd0);
        check("t2_sec_cnt_cleared", sec_cnt, 32'd0);

        // 3: write held off until the controller is initialised.
        sd_init_done = 1'b0;
        stream(256, 16'd1000, 1'b0, acc);
        check("t3_accepted", 32'(acc), 32'd256);
        count_starts(20, nst);
        check("t3_no_start_uninit", 32'(nst), 32'd0);
        sd_init_done = 1'b1;
        wait_start("t3", 32'h0000_3000, 2);
        ctrl_reqs("t3", 16'd1000, 256, 256);
        ctrl_finish("t3", 1'b0, 32'd1);

        // 4: asynchronous reset in the middle of a transfer.
        stream(256, 16'd2000, 1'b0, acc);
        wait_start("t4", 32'h0000_3001, 50);
        ctrl_reqs("t4", 16'd2000, 256, 100);
        #2;
        rst = 1'b1;
        #1;
        check("t4_rst_wr_start_en", 32'(wr_start_en), 32'd0);
        check("t4_rst_wr_sec_addr", wr_sec_addr, 32'd0);
        check("t4_rst_wr_data", 32'(wr_data), 32'd0);
        check("t4_rst_sec_cnt", sec_cnt, 32'd0);
        check("t4_rst_frame_done", 32'(frame_done), 32'd0);
        check("t4_rst_overflow", 32'(overflow), 32'd0);
        check("t4_rst_pix_ready", 32'(pix_ready), 32'd0);
        tick();
        wr_busy = 1'b0;
        tick();
        rst = 1'b0;
        count_starts(30, nst);
        check("t4_no_start_after_rst", 32'(nst), 32'd0);

        // 5: 300 words, frame_end with the last word.
        pulse_start(32'h0000_4000);
        fork
            begin
                stream(300, 16'd5000, 1'b1, acc2);
                check("t5_accepted", 32'(acc2), 32'd300);
                check("t5_ready_after_end", 32'(pix_ready), 32'd0);
            end
            begin
                wait_start("t5_s0", 32'h0000_4000, 2000);
                ctrl_reqs("t5_s0", 16'd5000, 256, 256);
`ifdef SD_PAD_PARTIAL_EN
                ctrl_finish("t5_s0", 1'b0, 32'd1);
                wait_start("t5_s1", 32'h0000_4001, 50);
                ctrl_reqs("t5_s1", 16'd5256, 44, 256);
                ctrl_finish("t5_s1", 1'b1, 32'd2);
`else
                ctrl_finish("t5_s0", 1'b1, 32'd1);
                count_starts(30, nst);
                check("t5_partial_dropped", 32'(nst), 32'd0);
`endif
            end
        join

        // 6: surplus wr_req on one sector; address wraps past 0xFFFF_FFFF.
        pulse_start(32'hFFFF_FFFF);
        fork
            begin
                stream(512, 16'h7000, 1'b0, acc);
                check("t6_accepted", 32'(acc), 32'd512);
                pulse_end();
            end
            begin
                wait_start("t6_s0", 32'hFFFF_FFFF, 2000);
                ctrl_reqs("t6_s0", 16'h7000, 256, 258);
                ctrl_finish("t6_s0", 1'b0, 32'd1);
                wait_start("t6_s1", 32'h0000_0000, 2000);
                ctrl_reqs("t6_s1", 16'h7100, 256, 256);
                ctrl_finish("t6_s1", 1'b1, 32'd2);
            end
        join

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
